// File: rtl/vdu_timing_pkg.sv
// Shared types and default 640x480 timing for the VGA raster timing controller.
package vdu_timing_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } vdu_state_t;

   localparam int   H_ACTIVE_DEF = 640;
   localparam int   H_FP_DEF     = 16;
   localparam int   H_SYNC_DEF   = 96;
   localparam int   H_BP_DEF     = 48;
   localparam int   V_ACTIVE_DEF = 480;
   localparam int   V_FP_DEF     = 10;
   localparam int   V_SYNC_DEF   = 2;
   localparam int   V_BP_DEF     = 33;
   localparam logic HS_POL_DEF   = 1'b0;
   localparam logic VS_POL_DEF   = 1'b0;
   localparam int   CNT_W_DEF    = 10;

   function automatic int h_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int v_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vdu_wrap_counter.sv
// Enabled up-counter that wraps to zero after wrap_val; exposes its next value
// so the parent can register decodes on the same edge as the count.
module vdu_wrap_counter
   import vdu_timing_pkg::*;
#(
   parameter int W = CNT_W_DEF
) (
   input  logic         sysclk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] wrap_val,
   output logic [W-1:0] cnt,
   output logic [W-1:0] nxt,
   output logic         wrap
);

   assign wrap = en && (cnt == wrap_val);

   always_comb begin
      nxt = cnt;
      if (clr || wrap) begin
         nxt = '0;
      end else if (en) begin
         nxt = cnt + W'(1);
      end
   end

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= nxt;
      end
   end

endmodule

// File: rtl/vdu_timing_ctrl.sv
// Raster timing controller: counts pixel strobes through a frame and stops only on a
// frame boundary. Optional per-line compare interrupt enabled by VDU_LINE_IRQ_EN.
module vdu_timing_ctrl
   import vdu_timing_pkg::*;
#(
   parameter int   H_ACTIVE = H_ACTIVE_DEF,
   parameter int   H_FP     = H_FP_DEF,
   parameter int   H_SYNC   = H_SYNC_DEF,
   parameter int   H_BP     = H_BP_DEF,
   parameter int   V_ACTIVE = V_ACTIVE_DEF,
   parameter int   V_FP     = V_FP_DEF,
   parameter int   V_SYNC   = V_SYNC_DEF,
   parameter int   V_BP     = V_BP_DEF,
   parameter logic HS_POL   = HS_POL_DEF,
   parameter logic VS_POL   = VS_POL_DEF,
   parameter int   CNT_W    = CNT_W_DEF
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic             pix_en,
   input  logic             run,
`ifdef VDU_LINE_IRQ_EN
   input  logic [CNT_W-1:0] line_cmp,
   output logic             line_irq,
`endif
   output logic             busy,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             line_start,
   output logic             frame_start
);

   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   vdu_state_t       state;
   vdu_state_t       state_nxt;
   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] vcnt;
   logic [CNT_W-1:0] hn;
   logic [CNT_W-1:0] vn;
   logic             hwrap;
   logic             vwrap;
   logic             adv;
   logic             clr;
   logic             pulse;

   assign adv   = pix_en && (state != IDLE);
   assign clr   = (state_nxt == IDLE);
   assign pulse = pix_en && (state_nxt != IDLE) && (hn == '0);

   vdu_wrap_counter #(.W(CNT_W)) u_hcnt (
      .sysclk   (sysclk),
      .rst_n    (rst_n),
      .clr      (clr),
      .en       (adv),
      .wrap_val (H_LAST),
      .cnt      (hcnt),
      .nxt      (hn),
      .wrap     (hwrap)
   );

   // vwrap doubles as the end-of-frame strobe
   vdu_wrap_counter #(.W(CNT_W)) u_vcnt (
      .sysclk   (sysclk),
      .rst_n    (rst_n),
      .clr      (clr),
      .en       (hwrap),
      .wrap_val (V_LAST),
      .cnt      (vcnt),
      .nxt      (vn),
      .wrap     (vwrap)
   );

   assign x = hcnt;
   assign y = vcnt;

   // A draining frame only stops if run is still low on its final strobe.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (pix_en && run) begin
               state_nxt = RUN;
            end
         end
         RUN, DRAIN: begin
            if (vwrap && (state == DRAIN) && !run) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = run ? RUN : DRAIN;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
`ifdef VDU_LINE_IRQ_EN
         line_irq    <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         busy        <= (state_nxt != IDLE);
         line_start  <= pulse;
         frame_start <= pulse && (vn == '0);
`ifdef VDU_LINE_IRQ_EN
         line_irq    <= pulse && (vn == line_cmp);
`endif
         if (state_nxt == IDLE) begin
            de    <= 1'b0;
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
         end else if (pix_en) begin
            de    <= (hn < H_VIS) && (vn < V_VIS);
            hsync <= ((hn >= HS_BEG) && (hn <= HS_END)) ? HS_POL : ~HS_POL;
            vsync <= ((vn >= VS_BEG) && (vn <= VS_END)) ? VS_POL : ~VS_POL;
         end
      end
   end

endmodule

// File: tb/tb_vdu_timing_ctrl.sv
// Randomized bench for vdu_timing_ctrl on a shrunken raster, checked every cycle
// against a position/activity model of the frame rules.
module tb_vdu_timing_ctrl;

   localparam int   HA  = 20;
   localparam int   HFP = 3;
   localparam int   HSY = 5;
   localparam int   HBP = 4;
   localparam int   VA  = 6;
   localparam int   VFP = 2;
   localparam int   VSY = 2;
   localparam int   VBP = 2;
   localparam int   CW  = 5;
   localparam int   HT  = HA + HFP + HSY + HBP;
   localparam int   VT  = VA + VFP + VSY + VBP;
   localparam logic HSP = 1'b0;
   localparam logic VSP = 1'b1;

   logic          sysclk = 1'b0;
   logic          rst_n  = 1'b0;
   logic          pix_en = 1'b0;
   logic          run    = 1'b0;
   logic          busy;
   logic          hsync;
   logic          vsync;
   logic          de;
   logic [CW-1:0] x;
   logic [CW-1:0] y;
   logic          line_start;
   logic          frame_start;
`ifdef VDU_LINE_IRQ_EN
   logic [CW-1:0] line_cmp = CW'(VA - 1);
   logic          line_irq;
`endif

   int    vectors     = 0;
   int    miscompares = 0;
   int    mx = 0;
   int    my = 0;
   bit    mActive = 1'b0;
   bit    mDrain  = 1'b0;
   bit    mLs = 1'b0;
   bit    mFs = 1'b0;
   int    lineCmp = VA - 1;
   logic  runVal;
   string phase = "reset";

   always #5 sysclk = ~sysclk;

   vdu_timing_ctrl #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .HS_POL(HSP), .VS_POL(VSP), .CNT_W(CW)
   ) dut (
      .sysclk      (sysclk),
      .rst_n       (rst_n),
      .pix_en      (pix_en),
      .run         (run),
`ifdef VDU_LINE_IRQ_EN
      .line_cmp    (line_cmp),
      .line_irq    (line_irq),
`endif
      .busy        (busy),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .x           (x),
      .y           (y),
      .line_start  (line_start),
      .frame_start (frame_start)
   );

   // Reference model: a frame is a walk over HT*VT positions; stopping is only
   // allowed when the last position is left while a stop request is pending.
   function automatic void modelStep(input logic r, input logic pe, input logic rn);
      bit lastPixel;
      mLs = 1'b0;
      mFs = 1'b0;
      if (!r) begin
         mActive = 1'b0;
         mDrain  = 1'b0;
         mx = 0;
         my = 0;
         return;
      end
      if (!mActive) begin
         if (pe && rn) begin
            mActive = 1'b1;
            mx = 0;
            my = 0;
            mLs = 1'b1;
            mFs = 1'b1;
         end
      end else if (pe) begin
         lastPixel = (mx == HT - 1) && (my == VT - 1);
         mx = (mx + 1) % HT;
         if (mx == 0) my = (my + 1) % VT;
         if (lastPixel && mDrain && !rn) begin
            mActive = 1'b0;
         end else if (mx == 0) begin
            mLs = 1'b1;
            mFs = (my == 0);
         end
      end
      mDrain = mActive && !rn;
   endfunction

   function automatic logic [63:0] expectedVec();
      logic eDe, eHs, eVs, eIrq;
      eDe  = mActive && (mx < HA) && (my < VA);
      eHs  = (mActive && (mx >= HA + HFP) && (mx < HA + HFP + HSY)) ? HSP : ~HSP;
      eVs  = (mActive && (my >= VA + VFP) && (my < VA + VFP + VSY)) ? VSP : ~VSP;
      eIrq = mLs && (my == lineCmp);
`ifndef VDU_LINE_IRQ_EN
      eIrq = 1'b0;
`endif
      return 64'({mActive, eHs, eVs, eDe, mLs, mFs, eIrq, CW'(mx), CW'(my)});
   endfunction

   function automatic logic [63:0] actualVec();
      logic aIrq;
`ifdef VDU_LINE_IRQ_EN
      aIrq = line_irq;
`else
      aIrq = 1'b0;
`endif
      return 64'({busy, hsync, vsync, de, line_start, frame_start, aIrq, x, y});
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h (model pos %0d,%0d) t=%0t",
                  tag, obs, exp, mx, my, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic pe, input logic rn);
      rst_n  = r;
      pix_en = pe;
      run    = rn;
      @(posedge sysclk);
      modelStep(r, pe, rn);
      #1;
      checkOutput(phase, actualVec(), expectedVec());
   endtask

   task automatic runTo(input int tx, input int ty, input logic rn, input int density);
      int guard = 0;
      while (!(mActive && mx == tx && my == ty) && guard < 5000) begin
         applyStimulus(1'b1, ($urandom_range(0, 99) < density), rn);
         guard++;
      end
      checkOutput({phase, "_reach"}, 64'(mActive && mx == tx && my == ty), 64'(1));
   endtask

   task automatic setLineCmp(input int v);
      lineCmp = v;
`ifdef VDU_LINE_IRQ_EN
      line_cmp = CW'(v);
`endif
   endtask

   initial begin
      $display("[TB] raster %0dx%0d, frame %0d strobes", HT, VT, HT * VT);

      phase = "reset";
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, i[0], 1'b1);

      phase = "start";
      for (int i = 0; i < 5 * HT * VT * 2 + 10; i++) applyStimulus(1'b1, (i % 5) == 0, 1'b1);

      phase = "drain";
      runTo(10, 5, 1'b1, 50);
      begin
         int guard = 0;
         while (mActive && guard < 5000) begin
            applyStimulus(1'b1, $urandom_range(0, 99) < 50, 1'b0);
            guard++;
         end
      end
      checkOutput("drain_idle", 64'(busy), 64'(0));
      for (int i = 0; i < 60; i++) applyStimulus(1'b1, $urandom_range(0, 1) == 1, 1'b0);

      phase = "rerun";
      applyStimulus(1'b1, 1'b1, 1'b1);
      runTo(5, 2, 1'b1, 40);
      runTo(0, 7, 1'b0, 40);
      runTo(HT - 1, VT - 1, 1'b1, 40);
      for (int i = 0; i < 3 * HT; i++) applyStimulus(1'b1, $urandom_range(0, 1) == 1, 1'b1);

      phase = "eofcorner";
      runTo(HT - 1, VT - 1, 1'b1, 60);
      applyStimulus(1'b1, 1'b1, 1'b0);
      runTo(HT - 1, VT - 1, 1'b0, 60);
      applyStimulus(1'b1, 1'b1, 1'b1);
      runTo(HT - 1, VT - 1, 1'b0, 60);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("eof_stop", 64'({busy, x, y}), 64'(0));

      phase = "midreset";
      applyStimulus(1'b1, 1'b1, 1'b1);
      runTo(15, 3, 1'b1, 50);
      applyStimulus(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 2 * HT * VT; i++) applyStimulus(1'b1, $urandom_range(0, 3) != 0, 1'b1);

      phase = "linecmp_hi";
      setLineCmp(VT + 5);
      for (int i = 0; i < 3 * HT * VT; i++) applyStimulus(1'b1, 1'b1, 1'b1);
      setLineCmp(0);
      for (int i = 0; i < HT * VT + 5; i++) applyStimulus(1'b1, 1'b1, 1'b1);

      phase = "random";
      runVal = 1'b1;
      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(0, 299) == 0) runVal = ~runVal;
         if ($urandom_range(0, 999) == 0) setLineCmp($urandom_range(0, VT + 3));
         applyStimulus($urandom_range(0, 1999) != 0, $urandom_range(0, 99) < 40, runVal);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
